// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, word-addressed imem requests, a one-entry
// skid for data acknowledged while the pipeline is stalled, and the IF/ID register.
module ifetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_imem_req,
    output logic [29:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc4,
    output logic [31:0] o_if_instr,
    output logic [5:0]  o_if_op,
    output logic [5:0]  o_if_fun,
    output logic        o_halted,
    output logic [31:0] o_fetch_cnt
);

    typedef enum logic [1:0] {StFetch, StHold, StHalted} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic [31:0] r_if_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_fetch_cnt;

    logic        w_running;
    logic        w_flush;
    logic        w_take_redirect;
    logic        w_fetch_ok;
    logic        w_load_mem;
    logic        w_to_skid;
    logic        w_bubble;
    logic        w_load_skid;
    logic [31:0] w_pc4;
    logic [31:0] w_skid_pc4;
    logic [31:0] w_target;

    // Decode the per-edge action; halt outranks redirect, which outranks stall.
    always_comb begin
        w_running       = (r_state != StHalted);
        w_flush         = w_running && (i_halt || i_redirect);
        w_take_redirect = w_running && !i_halt && i_redirect;
        w_fetch_ok      = (r_state == StFetch) && !i_halt && !i_redirect;
        w_load_mem      = w_fetch_ok && i_imem_ack && !i_stall;
        w_to_skid       = w_fetch_ok && i_imem_ack && i_stall;
        w_bubble        = w_fetch_ok && !i_imem_ack && !i_stall;
        w_load_skid     = (r_state == StHold) && !i_halt && !i_redirect && !i_stall;
        w_pc4           = r_pc + 32'd4;
        w_skid_pc4      = r_skid_pc + 32'd4;
        w_target        = i_redirect_pc & ~32'd3;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFetch: begin
                if (i_halt) begin
                    w_state_next = StHalted;
                end else if (i_redirect) begin
                    w_state_next = StFetch;
                end else if (i_imem_ack && i_stall) begin
                    w_state_next = StHold;
                end
            end
            StHold: begin
                if (i_halt) begin
                    w_state_next = StHalted;
                end else if (i_redirect || !i_stall) begin
                    w_state_next = StFetch;
                end
            end
            StHalted: w_state_next = StHalted;
            default:  w_state_next = StFetch;
        endcase
    end

    // State-decoded outputs; the request is gated by reset so it drops immediately.
    always_comb begin
        o_imem_req = (r_state == StFetch) && rst_n;
        o_halted   = (r_state == StHalted);
    end

    // Program counter: redirect target or sequential advance on an accepted ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= PC_RESET;
        end else if (w_take_redirect) begin
            r_pc <= w_target;
        end else if (w_load_mem || w_to_skid) begin
            r_pc <= w_pc4;
        end
    end

    // Skid entry captures a word acknowledged while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_pc    <= 32'd0;
            r_skid_instr <= 32'd0;
        end else if (w_to_skid) begin
            r_skid_pc    <= r_pc;
            r_skid_instr <= i_imem_rdata;
        end
    end

    // IF/ID register: loaded from memory or skid, bubbled on flush or empty fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_pc4   <= 32'd0;
            r_if_instr <= 32'd0;
        end else if (w_flush || w_bubble) begin
            r_if_valid <= 1'b0;
        end else if (w_load_mem) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_pc;
            r_if_pc4   <= w_pc4;
            r_if_instr <= i_imem_rdata;
        end else if (w_load_skid) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_skid_pc;
            r_if_pc4   <= w_skid_pc4;
            r_if_instr <= r_skid_instr;
        end
    end

    // Count every instruction that enters IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_load_mem || w_load_skid) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign o_imem_addr = r_pc[31:2];
    assign o_if_valid  = r_if_valid;
    assign o_if_pc     = r_if_pc;
    assign o_if_pc4    = r_if_pc4;
    assign o_if_instr  = r_if_instr;
    assign o_if_op     = r_if_instr[31:26];
    assign o_if_fun    = r_if_instr[5:0];
    assign o_fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed and random stimulus for ifetch_unit against a queue-based reference model.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        o_imem_req;
    logic [29:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_if_valid;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_pc4;
    logic [31:0] o_if_instr;
    logic [5:0]  o_if_op;
    logic [5:0]  o_if_fun;
    logic        o_halted;
    logic [31:0] o_fetch_cnt;

    ifetch_unit #(.PC_RESET(32'h0000_3000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_stall      (i_stall),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .i_halt       (i_halt),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_rdata (i_imem_rdata),
        .o_if_valid   (o_if_valid),
        .o_if_pc      (o_if_pc),
        .o_if_pc4     (o_if_pc4),
        .o_if_instr   (o_if_instr),
        .o_if_op      (o_if_op),
        .o_if_fun     (o_if_fun),
        .o_halted     (o_halted),
        .o_fetch_cnt  (o_fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the fetcher is either requesting, waiting on a parked word
    // (queue non-empty), or halted.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } parked_t;

    parked_t     m_parked[$];
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;
    logic        m_halted;

    function automatic logic [31:0] mem_word(input logic [29:0] widx);
        return {2'b00, widx} ^ 32'hDEAD_0000;
    endfunction

    function automatic logic exp_req();
        return rst_n && !m_halted && (m_parked.size() == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] a;
        a = m_pc;
        chk("imem_req", {31'd0, o_imem_req}, {31'd0, exp_req()});
        chk("imem_addr", {2'b00, o_imem_addr}, {2'b00, a[31:2]});
        chk("if_valid", {31'd0, o_if_valid}, {31'd0, m_valid});
        chk("if_pc", o_if_pc, m_ipc);
        chk("if_pc4", o_if_pc4, m_ipc4);
        chk("if_instr", o_if_instr, m_instr);
        chk("if_op", {26'd0, o_if_op}, {26'd0, m_instr[31:26]});
        chk("if_fun", {26'd0, o_if_fun}, {26'd0, m_instr[5:0]});
        chk("halted", {31'd0, o_halted}, {31'd0, m_halted});
        chk("fetch_cnt", o_fetch_cnt, m_cnt);
    endtask

    task automatic model_reset();
        m_parked.delete();
        m_pc     = 32'h0000_3000;
        m_valid  = 1'b0;
        m_ipc    = 32'd0;
        m_ipc4   = 32'd0;
        m_instr  = 32'd0;
        m_cnt    = 32'd0;
        m_halted = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic hl, input logic ak, input logic [31:0] data);
        parked_t p;
        if (m_halted) begin
            // frozen until reset
        end else if (hl) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
            m_parked.delete();
        end else if (rd) begin
            m_pc    = {rpc[31:2], 2'b00};
            m_valid = 1'b0;
            m_parked.delete();
        end else if (m_parked.size() != 0) begin
            if (!st) begin
                p       = m_parked.pop_front();
                m_ipc   = p.pc;
                m_ipc4  = p.pc + 32'd4;
                m_instr = p.instr;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
        end else if (ak) begin
            if (st) begin
                p.pc    = m_pc;
                p.instr = data;
                m_parked.push_back(p);
            end else begin
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 32'd4;
                m_instr = data;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: apply inputs, advance the model, then check just after the edge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic hl, input logic ak);
        logic [31:0] a;
        a             = m_pc;
        i_stall       = st;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        i_halt        = hl;
        i_imem_ack    = ak;
        i_imem_rdata  = mem_word(a[31:2]);
        model_step(st, rd, rpc, hl, ak, i_imem_rdata);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        i_halt        = 1'b0;
        i_imem_ack    = 1'b0;
        i_imem_rdata  = 32'd0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b1;
        model_reset();
        #3;

        // Reset values, then zero-wait memory: 0x3000, 0x3004, 0x3008.
        do_reset();
        chk("reset_addr", {2'b00, o_imem_addr}, 32'h0000_0C00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("zw_pc", o_if_pc, 32'h0000_3008);
        chk("zw_cnt", o_fetch_cnt, 32'd3);

        // Three-cycle memory latency: two bubbles between instructions.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        end
        chk("lat_cnt", o_fetch_cnt, 32'd6);

        // Ack under stall parks the word; it appears one edge after stall falls.
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("hold_req", {31'd0, o_imem_req}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("skid_pc", o_if_pc, 32'h0000_3018);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Redirect with ack and stall: flush, discard the word, target 0x3040.
        cycle(1'b1, 1'b1, 32'h0000_3042, 1'b0, 1'b1);
        chk("redir_addr", {2'b00, o_imem_addr}, 32'h0000_0C10);
        chk("redir_valid", {31'd0, o_if_valid}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("redir_tgt", o_if_pc, 32'h0000_3040);

        // Halt during HOLD, ignored redirect, then restart from reset.
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_5000, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("halt_flag", {31'd0, o_halted}, 32'd1);
        do_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("restart_pc", o_if_pc, 32'h0000_3000);

        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("wrap_addr", {2'b00, o_imem_addr}, 32'd0);
        chk("wrap_pc4", o_if_pc4, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Random traffic with occasional reset, including mid-cycle reset.
        for (int i = 0; i < 800; i++) begin
            logic st, rd, hl, ak;
            logic [31:0] rpc;
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                st  = ($urandom_range(0, 3) == 0);
                rd  = ($urandom_range(0, 19) == 0);
                rpc = $urandom;
                hl  = ($urandom_range(0, 149) == 0);
                ak  = exp_req() && ($urandom_range(0, 1) == 1);
                cycle(st, rd, rpc, hl, ak);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
